// File: rtl/chunked_adder_hex_pkg.sv
// Shared types and seven-segment tables for the chunked hex adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F.
  localparam logic [6:0] SEG_N [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/chunked_adder_hex_if.sv
// Operand/result bus of the chunked adder; master drives operands, slave returns the sum.
interface chunked_adder_hex_if #(
  parameter int WIDTH = 16
);
  localparam int NDIG = (WIDTH + 4) / 4;

  logic                  start;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  cin;
  logic                  acc_mode;
  logic                  busy;
  logic                  done;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        LEDR;
  logic [7*NDIG-1:0]     hex_n;

  modport master (
    output start, a, b, cin, acc_mode,
    input  busy, done, sum, LEDR, hex_n
  );

  modport slave (
    input  start, a, b, cin, acc_mode,
    output busy, done, sum, LEDR, hex_n
  );
endinterface

// File: rtl/chunked_adder_hex_hex7seg.sv
// Single hex digit to active-low seven-segment decoder.
module hex7seg
  import adder_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_N[i_nib];
endmodule

// File: rtl/chunked_adder_hex.sv
// Sequential adder, CHUNK bits per clock, with LED and hex display of the registered sum.
// Optional accumulator operand enabled by defining ADDER_ACCUM_EN.
module chunked_adder_hex
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  chunked_adder_hex_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NDIG   = (WIDTH + 4) / 4;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_adder_hex: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_opa, r_opb, r_res, w_res_next, w_opa_src;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH:0]    r_sum;
  logic [CHUNK:0]    w_add;
  logic              w_last, w_busy, w_done;

`ifdef ADDER_ACCUM_EN
  logic [WIDTH-1:0]  r_acc;

  assign w_opa_src = bus.acc_mode ? r_acc : bus.a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_acc <= '0;
    else if (r_state == RUN && w_last)
      r_acc <= w_res_next;
  end
`else
  logic w_unused_acc_mode;

  assign w_unused_acc_mode = bus.acc_mode;
  assign w_opa_src         = bus.a;
`endif

  assign w_add  = {1'b0, r_opa[r_idx*CHUNK +: CHUNK]}
                + {1'b0, r_opb[r_idx*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_idx == IDXW'(NCHUNK - 1));

  always_comb begin
    w_res_next = r_res;
    w_res_next[r_idx*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:                   w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN:  w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // The sum is committed on the final chunk so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_opa   <= w_opa_src;
          r_opb   <= bus.b;
          r_carry <= bus.cin;
          r_idx   <= '0;
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_add[CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) r_sum <= {w_add[CHUNK], w_res_next};
        end
        default: ;
      endcase
    end
  end

  logic [NDIG*4-1:0] w_nibs;
  assign w_nibs = (NDIG*4)'(r_sum);

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      hex7seg u_hex (
        .i_nib (w_nibs[4*gi +: 4]),
        .o_seg (bus.hex_n[7*gi +: 7])
      );
    end
  endgenerate

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.LEDR = r_sum;

endmodule

// File: tb/tb_chunked_adder_hex.sv
// Self-checking bench for chunked_adder_hex against an arithmetic reference model.
module tb_chunked_adder_hex;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NDIG  = (WIDTH + 4) / 4;
  localparam int LAT   = WIDTH / CHUNK + 1;
`ifdef ADDER_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_adder_hex_if #(.WIDTH(WIDTH)) bus();

  chunked_adder_hex #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] acc_model;
  logic [6:0] seg_tab [16];

  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a, b,
                                                input logic c, acc);
    logic [WIDTH-1:0] opa;
    opa = (ACC_EN && acc) ? acc_model : a;
    return {1'b0, opa} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and waits for done; lat counts cycles from acceptance to done.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic c, acc,
                        output int lat, output bit busy_ok);
    bus.a = a; bus.b = b; bus.cin = c; bus.acc_mode = acc; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    busy_ok = bus.busy;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [6:0] d;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.acc_mode = 1'b0;
    acc_model = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0", bus.sum); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    for (int i = 0; i < NDIG; i++) begin
      d = bus.hex_n[7*i +: 7];
      checks++;
      if (d !== 7'b1000000) begin errors++; $display("FAIL reset_hex%0d got %b want 1000000", i, d); end
    end
  endtask

  task automatic test_basic();
    int lat; bit bok;
    logic [WIDTH:0] exp;
    logic [NDIG*4-1:0] ext;
    logic [3:0] nib;
    exp = model_sum(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bok);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy got low want high during run"); end
    checks++; if (bus.sum !== 17'h05555) begin errors++; $display("FAIL basic_sum got %h want 05555", bus.sum); end
    checks++; if (bus.LEDR !== exp) begin errors++; $display("FAIL basic_ledr got %h want %h", bus.LEDR, exp); end
    ext = (NDIG*4)'(exp);
    for (int i = 0; i < NDIG; i++) begin
      nib = ext[4*i +: 4];
      checks++;
      if (bus.hex_n[7*i +: 7] !== seg_tab[nib])
        begin errors++; $display("FAIL basic_hex%0d got %b want %b", i, bus.hex_n[7*i +: 7], seg_tab[nib]); end
    end
    acc_model = exp[WIDTH-1:0];
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    checks++; if (bus.sum !== exp) begin errors++; $display("FAIL basic_hold got %h want %h", bus.sum, exp); end
  endtask

  task automatic test_carry();
    int lat; bit bok;
    logic [WIDTH:0] exp;
    logic [NDIG*4-1:0] ext;
    logic [3:0] nib;
    exp = model_sum(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, bok);
    checks++; if (bus.sum !== exp) begin errors++; $display("FAIL carry_sum got %h want %h", bus.sum, exp); end
    checks++; if (bus.LEDR[WIDTH] !== 1'b1) begin errors++; $display("FAIL carry_led16 got %b want 1", bus.LEDR[WIDTH]); end
    ext = (NDIG*4)'(exp);
    for (int i = 0; i < NDIG; i++) begin
      nib = ext[4*i +: 4];
      checks++;
      if (bus.hex_n[7*i +: 7] !== seg_tab[nib])
        begin errors++; $display("FAIL carry_hex%0d got %b want %b", i, bus.hex_n[7*i +: 7], seg_tab[nib]); end
    end
    acc_model = exp[WIDTH-1:0];
    tick();
  endtask

  task automatic test_busy_reject();
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] exp;
    int dones;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    exp = model_sum(a, b, 1'b0, 1'b0);
    bus.a = a; bus.b = b; bus.cin = 1'b0; bus.acc_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 16'h0001; bus.b = 16'h0001; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      tick();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL reject_dones got %0d want 1", dones); end
    checks++; if (bus.sum !== exp) begin errors++; $display("FAIL reject_sum got %h want %h", bus.sum, exp); end
    acc_model = exp[WIDTH-1:0];
  endtask

  task automatic test_reset_mid();
    int lat, dones; bit bok;
    logic [WIDTH:0] exp;
    bus.a = 16'hABCD; bus.b = 16'h1111; bus.cin = 1'b1; bus.acc_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    acc_model = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL midrst_sum got %h want 0", bus.sum); end
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_dones got %0d want 0", dones); end
    exp = model_sum(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat, bok);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
    checks++; if (bus.sum !== exp) begin errors++; $display("FAIL midrst_sum2 got %h want %h", bus.sum, exp); end
    acc_model = exp[WIDTH-1:0];
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic [WIDTH:0] e1, e2;
    int n;
    a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
    a2 = WIDTH'($urandom); b2 = WIDTH'($urandom);
    e1 = model_sum(a1, b1, 1'b1, 1'b0);
    bus.a = a1; bus.b = b1; bus.cin = 1'b1; bus.acc_mode = 1'b0; bus.start = 1'b1;
    tick();
    n = 1;
    while (!bus.done && n < 20) begin tick(); n++; end
    checks++; if (bus.sum !== e1) begin errors++; $display("FAIL b2b_sum1 got %h want %h", bus.sum, e1); end
    acc_model = e1[WIDTH-1:0];
    e2 = model_sum(a2, b2, 1'b0, 1'b0);
    bus.a = a2; bus.b = b2; bus.cin = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", bus.busy); end
    n = 1;
    while (!bus.done && n < 20) begin tick(); n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, LAT); end
    checks++; if (bus.sum !== e2) begin errors++; $display("FAIL b2b_sum2 got %h want %h", bus.sum, e2); end
    acc_model = e2[WIDTH-1:0];
    tick();
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [WIDTH-1:0] a, b;
    logic c, acc;
    logic [WIDTH:0] exp;
    for (int k = 0; k < 16; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      c = 1'($urandom); acc = 1'($urandom);
      exp = model_sum(a, b, c, acc);
      run_op(a, b, c, acc, lat, bok);
      checks++;
      if (lat !== LAT || bus.sum !== exp)
        begin errors++; $display("FAIL rand%0d got %h lat %0d want %h lat %0d", k, bus.sum, lat, exp, LAT); end
      acc_model = exp[WIDTH-1:0];
      if (k % 3 == 0) tick();
      tick();
    end
  endtask

  task automatic test_accum();
    int lat; bit bok;
    logic [WIDTH:0] want2;
    want2 = ACC_EN ? 17'h00012 : 17'h10009;
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat, bok);
    checks++; if (bus.sum !== 17'h00008) begin errors++; $display("FAIL accum_first got %h want 00008", bus.sum); end
    acc_model = bus.sum[WIDTH-1:0];
    tick();
    run_op(16'hFFFF, 16'h000A, 1'b0, 1'b1, lat, bok);
    checks++; if (bus.sum !== want2) begin errors++; $display("FAIL accum_second got %h want %h", bus.sum, want2); end
    tick();
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_basic();
    test_carry();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_accum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
